// File: rtl/approx_add_err_monitor.sv
// Error-metric monitor for the 4-bit OR-approximated adder: accumulates error count, error-distance sum and max over a window.
// Optional signed bias accumulator output ed_bias is enabled by defining APPROX_ERR_MON_BIAS_EN.
module approx_add_err_monitor #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_W-1:0]            num_samples,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [W-1:0]                in_a,
  input  logic [W-1:0]                in_b,
  input  logic [W:0]                  in_y,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            err_count,
  output logic [CNT_W+W:0]            ed_sum,
`ifdef APPROX_ERR_MON_BIAS_EN
  output logic signed [CNT_W+W+1:0]   ed_bias,
`endif
  output logic [W:0]                  ed_max
);

  localparam int SUM_W = CNT_W + W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   num_lat;
  logic [CNT_W-1:0]   accepted;
  logic               s1_valid;
  logic [W-1:0]       s1_a;
  logic [W-1:0]       s1_b;
  logic [W:0]         s1_y;
  logic               hs;

  logic [W:0]         exact;
  logic signed [W+1:0] diff;
  logic [W:0]         ed;
  logic [SUM_W:0]     sum_ext;

  // Ready is purely a function of the window count so it falls in the same
  // cycle the final sample is accepted.
  assign in_ready = (state == RUN) && (accepted < num_lat);
  assign hs       = in_valid && in_ready;

  always_comb begin
    exact   = {1'b0, s1_a} + {1'b0, s1_b};
    diff    = $signed({1'b0, exact}) - $signed({1'b0, s1_y});
    ed      = diff[W+1] ? (~diff[W:0] + {{W{1'b0}}, 1'b1}) : diff[W:0];
    sum_ext = {1'b0, ed_sum} + {{(CNT_W+1){1'b0}}, ed};
  end

`ifdef APPROX_ERR_MON_BIAS_EN
  localparam int BIAS_W = CNT_W + W + 2;
  logic signed [W+1:0]    bias_err;
  logic signed [BIAS_W:0] bias_ext;
  logic signed [BIAS_W-1:0] bias_next;

  // One extra headroom bit exposes overflow, which then clamps to signed max/min.
  always_comb begin
    bias_err  = $signed({1'b0, s1_y}) - $signed({1'b0, exact});
    bias_ext  = $signed({ed_bias[BIAS_W-1], ed_bias})
              + $signed({{(CNT_W+1){bias_err[W+1]}}, bias_err});
    bias_next = bias_ext[BIAS_W-1:0];
    if (bias_ext[BIAS_W] != bias_ext[BIAS_W-1])
      bias_next = bias_ext[BIAS_W] ? $signed({1'b1, {(BIAS_W-1){1'b0}}})
                                   : $signed({1'b0, {(BIAS_W-1){1'b1}}});
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_lat   <= '0;
      accepted  <= '0;
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_y      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      ed_sum    <= '0;
      ed_max    <= '0;
`ifdef APPROX_ERR_MON_BIAS_EN
      ed_bias   <= '0;
`endif
    end else begin
      s1_valid <= hs;
      if (hs) begin
        s1_a <= in_a;
        s1_b <= in_b;
        s1_y <= in_y;
      end

      // Stage 2: fold the registered sample into the saturating accumulators.
      if (s1_valid) begin
        if ((ed != '0) && (err_count != '1))
          err_count <= err_count + CNT_ONE;
        ed_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        if (ed > ed_max)
          ed_max <= ed;
`ifdef APPROX_ERR_MON_BIAS_EN
        ed_bias <= bias_next;
`endif
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_lat   <= num_samples;
            accepted  <= '0;
            err_count <= '0;
            ed_sum    <= '0;
            ed_max    <= '0;
`ifdef APPROX_ERR_MON_BIAS_EN
            ed_bias   <= '0;
`endif
            if (num_samples == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (hs) begin
            accepted <= accepted + CNT_ONE;
            if ((accepted + CNT_ONE) == num_lat)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Self-checking bench for approx_add_err_monitor: directed windows plus a randomized sweep against an arithmetic model.
module tb_approx_add_err_monitor;
  localparam int W     = 4;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [CNT_W-1:0]   num_samples;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_a;
  logic [W-1:0]       in_b;
  logic [W:0]         in_y;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   err_count;
  logic [CNT_W+W:0]   ed_sum;
  logic [W:0]         ed_max;

  int vectors     = 0;
  int miscompares = 0;
  int m_err, m_sum, m_max;

  always #5 clk = ~clk;

  approx_add_err_monitor #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_y(in_y),
    .busy(busy), .done(done), .err_count(err_count), .ed_sum(ed_sum), .ed_max(ed_max)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference approximate adder: low 3 bits ORed, upper bit added with carry from AND of bit 2.
  function automatic logic [4:0] goldenY(input logic [3:0] a, input logic [3:0] b);
    logic [2:0] lo;
    logic [1:0] hi;
    lo = a[2:0] | b[2:0];
    hi = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, a[2] & b[2]};
    return {hi, lo};
  endfunction

  task automatic clearModel();
    m_err = 0;
    m_sum = 0;
    m_max = 0;
  endtask

  task automatic startWindow(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    @(negedge clk);
    start       = 1'b0;
    clearModel();
  endtask

  // Offers one sample after `gap` idle cycles; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [4:0] y, input int gap);
    logic ok;
    int   exact, d;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      in_y = 5'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_y = y;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (ok) break;
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", {63'd0, ok}, 64'd1);
    if (ok) begin
      exact = int'(a) + int'(b);
      d = exact - int'(y);
      if (d < 0) d = -d;
      if (d != 0) m_err++;
      m_sum += d;
      if (d > m_max) m_max = d;
    end
  endtask

  task automatic checkDoneLatency(input string tag);
    checkOutput({tag, "_ready_low"}, {63'd0, in_ready}, 64'd0);
    checkOutput({tag, "_done_t0"}, {63'd0, done}, 64'd0);
    @(negedge clk);
    checkOutput({tag, "_done_t1"}, {63'd0, done}, 64'd0);
    checkOutput({tag, "_busy_t1"}, {63'd0, busy}, 64'd1);
    @(negedge clk);
    checkOutput({tag, "_done_t2"}, {63'd0, done}, 64'd1);
    checkOutput({tag, "_busy_t2"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic checkResults(input string tag);
    int e;
    e = (m_err > 65535) ? 65535 : m_err;
    checkOutput({tag, "_err_count"}, 64'(err_count), 64'(e));
    checkOutput({tag, "_ed_sum"}, 64'(ed_sum), 64'(m_sum));
    checkOutput({tag, "_ed_max"}, 64'(ed_max), 64'(m_max));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_y = '0;
    clearModel();
    #1;
    checkOutput("reset_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkResults("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single zero sample");
    startWindow(1);
    checkOutput("run_busy", {63'd0, busy}, 64'd1);
    applyStimulus(4'd0, 4'd0, 5'd0, 0);
    checkDoneLatency("single");
    checkResults("single");

    $display("[TB] two directed samples");
    startWindow(2);
    applyStimulus(4'd3, 4'd1, 5'd3, 0);
    applyStimulus(4'd15, 4'd15, 5'd31, 1);
    checkDoneLatency("pair");
    checkResults("pair");
    checkOutput("pair_err_const", 64'(err_count), 64'd2);
    checkOutput("pair_sum_const", 64'(ed_sum), 64'd2);
    checkOutput("pair_max_const", 64'(ed_max), 64'd1);

    $display("[TB] exhaustive golden sweep");
    startWindow(256);
    for (int i = 0; i < 256; i++)
      applyStimulus(4'(i >> 4), 4'(i), goldenY(4'(i >> 4), 4'(i)), int'($urandom_range(0, 2)));
    checkDoneLatency("sweep");
    checkResults("sweep");

    $display("[TB] random Y window");
    startWindow(20);
    for (int i = 0; i < 20; i++)
      applyStimulus(4'($urandom), 4'($urandom), 5'($urandom), int'($urandom_range(0, 1)));
    checkDoneLatency("rand");
    checkResults("rand");

    $display("[TB] zero-length window");
    startWindow(0);
    checkOutput("zero_done", {63'd0, done}, 64'd1);
    checkResults("zero");
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checkOutput("zero_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    $display("[TB] reset mid-window");
    startWindow(10);
    for (int i = 0; i < 5; i++)
      applyStimulus(4'($urandom), 4'($urandom), 5'(i + 1) ^ 5'd16, 0);
    rst_n = 1'b0;
    #1;
    clearModel();
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("midrst_done", {63'd0, done}, 64'd0);
    checkResults("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    startWindow(3);
    applyStimulus(4'd7, 4'd7, 5'd7, 0);
    applyStimulus(4'd9, 4'd2, 5'd11, 2);
    applyStimulus(4'd1, 4'd12, 5'd20, 1);
    checkDoneLatency("after_rst");
    checkResults("after_rst");

    $display("[TB] start ignored while running");
    startWindow(4);
    applyStimulus(4'd5, 4'd6, 5'd15, 0);
    applyStimulus(4'd2, 4'd2, 5'd4, 0);
    start = 1'b1;
    num_samples = 16'd1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_busy", {63'd0, busy}, 64'd1);
    checkOutput("restart_ready", {63'd0, in_ready}, 64'd1);
    applyStimulus(4'd8, 4'd8, 5'd0, 0);
    applyStimulus(4'd4, 4'd3, 5'd7, 1);
    checkDoneLatency("restart");
    checkResults("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, observed running, expected finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
